// File: rtl/my_multi_counter_if.sv
// Control/status bundle for the multi-channel timer core.
// The master side (bus bridge or testbench) drives the per-channel controls;
// the slave side (the counter core) returns counts and interrupt status.
interface my_multi_counter_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16,
    parameter int PRE_W  = 8
);
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       ack;
    logic [NUM_CH-1:0]       abort;
    logic [NUM_CH-1:0]       auto_reload;
    logic [NUM_CH*WIDTH-1:0] stop_val;
    logic [PRE_W-1:0]        prescale;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       irqStart;
    logic [NUM_CH-1:0]       irqDone;
    logic [NUM_CH-1:0]       overrun;
    logic                    irq;

    modport master (
        output start, ack, abort, auto_reload, stop_val, prescale,
        input  count, busy, irqStart, irqDone, overrun, irq
    );

    modport slave (
        input  start, ack, abort, auto_reload, stop_val, prescale,
        output count, busy, irqStart, irqDone, overrun, irq
    );
endinterface

// File: rtl/my_multi_counter.sv
// Multi-channel start/ack counter with a shared prescaler.
// Each channel counts 0..stop (latched at start) on prescaler ticks, flags
// completion in irqDone until acknowledged, and optionally auto-reloads.
module my_multi_counter #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16,
    parameter int PRE_W  = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    my_multi_counter_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick;

    logic [1:0]       state_q [NUM_CH];
    logic [1:0]       state_d [NUM_CH];
    logic [WIDTH-1:0] count_q [NUM_CH];
    logic [WIDTH-1:0] count_d [NUM_CH];
    logic [WIDTH-1:0] stop_q  [NUM_CH];
    logic [WIDTH-1:0] stop_d  [NUM_CH];
    logic [NUM_CH-1:0] auto_q, auto_d;
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] ovr_q, ovr_d;

    // Shared prescaler: >= compare so a lowered prescale never waits for a wrap
    always_comb begin
        tick      = (pre_cnt_q >= bus.prescale);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    end

    // Per-channel next state; priority abort > ack > start > tick
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        stop_d  = stop_q;
        auto_d  = auto_q;
        pulse_d = '0;
        done_d  = done_q;
        ovr_d   = ovr_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.abort[i]) begin
                state_d[i] = S_IDLE;
                count_d[i] = '0;
                done_d[i]  = 1'b0;
                ovr_d[i]   = 1'b0;
            end else begin
                case (state_q[i])
                    S_IDLE: begin
                        if (bus.start[i]) begin
                            state_d[i] = S_RUN;
                            count_d[i] = '0;
                            stop_d[i]  = bus.stop_val[i*WIDTH +: WIDTH];
                            auto_d[i]  = bus.auto_reload[i];
                            pulse_d[i] = 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (bus.ack[i]) begin
                            done_d[i] = 1'b0;
                            ovr_d[i]  = 1'b0;
                        end
                        // completion is applied after ack so it wins a same-cycle ack
                        if (tick) begin
                            if (count_q[i] == stop_q[i]) begin
                                done_d[i] = 1'b1;
                                if (auto_q[i]) begin
                                    count_d[i] = '0;
                                    if (done_q[i] && !bus.ack[i]) begin
                                        ovr_d[i] = 1'b1;
                                    end
                                end else begin
                                    state_d[i] = S_DONE;
                                end
                            end else begin
                                count_d[i] = count_q[i] + WIDTH'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        if (bus.ack[i]) begin
                            done_d[i]  = 1'b0;
                            ovr_d[i]   = 1'b0;
                            count_d[i] = '0;
                            if (bus.start[i]) begin
                                state_d[i] = S_RUN;
                                stop_d[i]  = bus.stop_val[i*WIDTH +: WIDTH];
                                auto_d[i]  = bus.auto_reload[i];
                                pulse_d[i] = 1'b1;
                            end else begin
                                state_d[i] = S_IDLE;
                            end
                        end
                    end
                    default: begin
                        state_d[i] = S_IDLE;
                        count_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            auto_q    <= '0;
            pulse_q   <= '0;
            done_q    <= '0;
            ovr_q     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= S_IDLE;
                count_q[i] <= '0;
                stop_q[i]  <= '0;
            end
        end else begin
            pre_cnt_q <= pre_cnt_d;
            state_q   <= state_d;
            count_q   <= count_d;
            stop_q    <= stop_d;
            auto_q    <= auto_d;
            pulse_q   <= pulse_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign bus.count[g*WIDTH +: WIDTH] = count_q[g];
        assign bus.busy[g]                 = (state_q[g] == S_RUN);
    end

    assign bus.irqStart = pulse_q;
    assign bus.irqDone  = done_q;
    assign bus.overrun  = ovr_q;
    assign bus.irq      = |done_q;

endmodule

// File: tb/tb_my_multi_counter.sv
// Self-checking bench for my_multi_counter: a tick-count reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_my_multi_counter;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 16;
    localparam int PRE_W  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    my_multi_counter_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

    my_multi_counter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 running, 2 done; n = ticks since launch
    int      m_phase [NUM_CH];
    longint  m_n     [NUM_CH];
    longint  m_stop  [NUM_CH];
    bit      m_auto  [NUM_CH];
    bit      m_pls   [NUM_CH];
    bit      m_done  [NUM_CH];
    bit      m_ovr   [NUM_CH];
    int      m_pre;
    bit      armed = 1'b0;

    // Advance the reference model on every rising edge
    always @(posedge clk) begin : model
        bit tick;
        bit was_done;
        if (!rst_n) begin
            m_pre = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_phase[c] = 0; m_n[c] = 0; m_stop[c] = 0; m_auto[c] = 0;
                m_pls[c] = 0; m_done[c] = 0; m_ovr[c] = 0;
            end
        end else begin
            tick = (m_pre >= int'(bus.prescale));
            m_pre = tick ? 0 : m_pre + 1;
            for (int c = 0; c < NUM_CH; c++) begin
                m_pls[c] = 0;
                was_done = m_done[c];
                if (bus.abort[c]) begin
                    m_phase[c] = 0; m_n[c] = 0; m_done[c] = 0; m_ovr[c] = 0;
                end else if (m_phase[c] == 0 || (m_phase[c] == 2 && bus.ack[c])) begin
                    if (m_phase[c] == 2) begin
                        m_done[c] = 0; m_ovr[c] = 0; m_phase[c] = 0; m_n[c] = 0;
                    end
                    if (bus.start[c]) begin
                        m_phase[c] = 1; m_n[c] = 0; m_pls[c] = 1;
                        m_stop[c] = longint'(bus.stop_val[c*WIDTH +: WIDTH]);
                        m_auto[c] = bus.auto_reload[c];
                    end
                end else if (m_phase[c] == 1) begin
                    if (bus.ack[c]) begin
                        m_done[c] = 0; m_ovr[c] = 0;
                    end
                    if (tick) begin
                        m_n[c]++;
                        if (m_n[c] % (m_stop[c] + 1) == 0) begin
                            if (m_auto[c] && was_done && !bus.ack[c]) m_ovr[c] = 1;
                            m_done[c] = 1;
                            if (!m_auto[c]) m_phase[c] = 2;
                        end
                    end
                end
            end
        end
        armed = 1'b1;
    end

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin : compare
        logic [NUM_CH*WIDTH-1:0] e_count;
        logic [NUM_CH-1:0] e_busy, e_pls, e_done, e_ovr;
        if (armed) begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (m_phase[c])
                    1:       e_count[c*WIDTH +: WIDTH] = WIDTH'(m_n[c] % (m_stop[c] + 1));
                    2:       e_count[c*WIDTH +: WIDTH] = WIDTH'(m_stop[c]);
                    default: e_count[c*WIDTH +: WIDTH] = '0;
                endcase
                e_busy[c] = (m_phase[c] == 1);
                e_pls[c]  = m_pls[c];
                e_done[c] = m_done[c];
                e_ovr[c]  = m_ovr[c];
            end
            check("count",    64'(bus.count),    64'(e_count));
            check("busy",     64'(bus.busy),     64'(e_busy));
            check("irqStart", 64'(bus.irqStart), 64'(e_pls));
            check("irqDone",  64'(bus.irqDone),  64'(e_done));
            check("overrun",  64'(bus.overrun),  64'(e_ovr));
            check("irq",      64'(bus.irq),      64'(|e_done));
        end
    end

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic set_stop(input int c, input int v);
        bus.stop_val[c*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    function automatic logic [WIDTH-1:0] cnt(input int c);
        return bus.count[c*WIDTH +: WIDTH];
    endfunction

    initial begin
        bus.start = '0; bus.ack = '0; bus.abort = '0; bus.auto_reload = '0;
        bus.stop_val = '0; bus.prescale = '0;

        // reset held with all starts asserted
        rst_n = 1'b0;
        bus.start = '1;
        repeat (3) next();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_irqStart", 64'(bus.irqStart), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_irq", 64'(bus.irq), 64'd0);
        rst_n = 1'b1;
        bus.start = '0;
        next();

        // one-shot, stop 5, prescale 0
        bus.prescale = 8'd0;
        set_stop(0, 5);
        bus.auto_reload[0] = 1'b0;
        bus.start[0] = 1'b1;
        next();
        bus.start[0] = 1'b0;
        check("os_irqStart", 64'(bus.irqStart[0]), 64'd1);
        check("os_busy", 64'(bus.busy[0]), 64'd1);
        repeat (5) next();
        check("os_cnt5_nodone", 64'({bus.irqDone[0], cnt(0)}), 64'h0_0005);
        next();
        check("os_done", 64'({bus.irqDone[0], bus.busy[0], cnt(0)}), 64'h2_0005);
        repeat (3) next();
        check("os_held", 64'(bus.irqDone[0]), 64'd1);
        bus.ack[0] = 1'b1;
        next();
        bus.ack[0] = 1'b0;
        check("os_ack", 64'({bus.irqDone[0], cnt(0)}), 64'd0);

        // prescale 3, stop 2; mid-run stop change ignored
        bus.prescale = 8'd3;
        set_stop(1, 2);
        bus.start[1] = 1'b1;
        next();
        bus.start[1] = 1'b0;
        repeat (3) next();
        set_stop(1, 50);
        repeat (9) next();
        check("pre_done", 64'({bus.irqDone[1], cnt(1)}), 64'h1_0002);
        bus.ack[1] = 1'b1;
        next();
        bus.ack[1] = 1'b0;

        // auto-reload stop 3: overrun on second wrap, ack on a wrap
        bus.prescale = 8'd0;
        set_stop(2, 3);
        bus.auto_reload[2] = 1'b1;
        bus.start[2] = 1'b1;
        next();
        bus.start[2] = 1'b0;
        repeat (4) next();
        check("ar_wrap1", 64'({bus.irqDone[2], bus.overrun[2], cnt(2)}), 64'h2_0000);
        repeat (4) next();
        check("ar_ovr", 64'({bus.irqDone[2], bus.overrun[2]}), 64'd3);
        repeat (3) next();
        bus.ack[2] = 1'b1;
        next();
        bus.ack[2] = 1'b0;
        check("ar_ack_wrap", 64'({bus.irqDone[2], bus.overrun[2]}), 64'd2);
        bus.abort[2] = 1'b1;
        next();
        bus.abort[2] = 1'b0;

        // abort mid-run at count 7
        set_stop(0, 100);
        bus.start[0] = 1'b1;
        next();
        bus.start[0] = 1'b0;
        repeat (7) next();
        check("ab_cnt7", 64'(cnt(0)), 64'd7);
        bus.abort[0] = 1'b1;
        next();
        bus.abort[0] = 1'b0;
        check("ab_clear", 64'({bus.busy[0], bus.irqDone[0], cnt(0)}), 64'd0);

        // ack+start together in DONE restarts directly
        set_stop(0, 1);
        bus.start[0] = 1'b1;
        next();
        bus.start[0] = 1'b0;
        repeat (2) next();
        check("rs_done", 64'(bus.irqDone[0]), 64'd1);
        set_stop(0, 4);
        bus.ack[0] = 1'b1;
        bus.start[0] = 1'b1;
        next();
        bus.ack[0] = 1'b0;
        bus.start[0] = 1'b0;
        check("rs_restart", 64'({bus.irqStart[0], bus.busy[0], bus.irqDone[0]}), 64'd6);

        // all channels, staggered starts, stop {0,1,10,65535}
        bus.abort = '1;
        next();
        bus.abort = '0;
        bus.auto_reload = '0;
        set_stop(0, 0); set_stop(1, 1); set_stop(2, 10); set_stop(3, 65535);
        bus.start = 4'b0001;
        next();
        bus.start = 4'b0010;
        next();
        check("s0_first_tick", 64'({bus.irqDone[0], bus.irq}), 64'd3);
        bus.start = 4'b0100;
        next();
        bus.start = 4'b1000;
        next();
        bus.start = '0;
        repeat (65540) next();
        check("full_range", 64'({bus.irqDone, cnt(3)}), 64'hF_FFFF);
        check("ch2_count", 64'(cnt(2)), 64'd10);
        bus.ack = '1;
        next();
        bus.ack = '0;

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            bus.start       = NUM_CH'($urandom);
            bus.ack         = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
            bus.abort       = ($urandom_range(0, 40) == 0) ? NUM_CH'($urandom) : '0;
            bus.auto_reload = NUM_CH'($urandom);
            for (int c = 0; c < NUM_CH; c++) set_stop(c, int'($urandom_range(0, 9)));
            if ($urandom_range(0, 49) == 0) bus.prescale = PRE_W'($urandom_range(0, 3));
            next();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
